risc16_mem_responder: RTL and testbench
=======================================

// Module: risc16_mem_responder
// PURPOSE
//  Synthesizable memory/MMIO responder on the risc16f instruction and data buses. It holds the
//  CPU in reset while a byte-stream loader fills program memory, then releases the CPU.
//  It serves combinational big-endian 16-bit reads on both ports and decodes LED registers.
//  It sits beside risc16f in the board top, in place of the bench behavioural memory.
// PARAMETERS
//  MEM_BYTES  4096     byte capacity, power of two; addresses wrap modulo MEM_BYTES
//  LED0_ADDR  16'h0200 MMIO word address for led[15:0]
//  LED2_ADDR  16'h0202 MMIO word address for led[23:16]
// PORTS
//  clk       in   1   single clock; all state updates on posedge
//  rst       in   1   asynchronous, active-low reset
//  iaddr     in   16  instruction byte address from CPU
//  ioe       in   1   instruction read enable
//  idin      out  16  instruction word to CPU
//  daddr     in   16  data byte address from CPU
//  doe       in   1   data read enable
//  dwe       in   1   data write enable
//  ddout     in   16  write data from CPU
//  ddin      out  16  read data to CPU
//  ld_start  in   1   begin load; sampled only in HOLD
//  ld_len    in   16  byte count to load, latched with ld_start
//  ld_valid  in   1   loader byte valid
//  ld_data   in   8   loader byte
//  ld_ready  out  1   responder accepts byte (valid & ready = transfer)
//  cpu_rst   out  1   active-high reset to risc16f
//  ld_done   out  1   one-cycle pulse when the load completes
//  led       out  24  {led2, led1, led0} MMIO register
// BEHAVIOUR
//  Reset (rst=0): state HOLD, cpu_rst=1, ld_ready=0, ld_done=0, led=0. RAM contents are not cleared.
//  FSM HOLD->LOAD on ld_start with ld_len!=0; cnt<=0, len<=ld_len.
//   HOLD->DONE on ld_start with ld_len==0.
//   LOAD: ld_ready=1; each transfer writes mem[cnt]<=ld_data, cnt++.
//   LOAD->DONE when the transfer with cnt==len-1 occurs.
//   DONE: ld_done=1 for one cycle, cpu_rst stays 1, then RUN.
//   RUN: cpu_rst=0. Terminal until the next reset. ld_start is ignored in LOAD, DONE and RUN.
//  ld_ready is 1 only in LOAD. cnt wraps modulo MEM_BYTES, so loads longer than MEM_BYTES overwrite from 0.
//  Reads are combinational, zero latency. Word base = addr & ~1; word = {mem[base], mem[base|1]} (big-endian).
//   idin=ioe?word(iaddr):16'h0000
//   ddin=doe?word(daddr):16'h0000
//   daddr==LED0_ADDR reads {led[15:8],led[7:0]}; daddr==LED2_ADDR reads {8'h00,led[23:16]}.
//  Writes are honoured only in RUN, on posedge with dwe=1.
//   LED0_ADDR: led[15:0]<=ddout.
//   LED2_ADDR: led[23:16]<=ddout[7:0]; ddout[15:8] is discarded and RAM is not written.
//   Any other address: both bytes of the word at daddr&~1 are written. An odd address writes the same aligned word.
//  dwe in HOLD/LOAD/DONE is ignored, so stray CPU cycles cannot corrupt the load.
//  Same-cycle read and write of the same word: the read returns the old data, and the new data is visible the next cycle.
//  ioe and doe may be active together; both ports are served independently every cycle.
//  Reset asserted mid-load: immediate return to HOLD with cpu_rst=1. Already written bytes are retained, and a new ld_start restarts at 0.
// STRUCTURE
//  risc16_pkg: typedef enum logic [1:0] {HOLD, LOAD, DONE, RUN} resp_state_t; LED0_ADDR/LED2_ADDR defaults.
//  Sub-module risc16_byte_ram: MEM_BYTES x 8, two combinational word-read ports.
//   One write port: either one byte (loader) or one aligned 16-bit word (CPU); the mux is in the parent.
//  The parent owns the FSM, the counter, MMIO decode and the read muxes.
// TESTING
//  1. Reset, ld_start with ld_len=4, bytes 12 34 56 78 -> ld_done pulses one cycle after byte 4, then cpu_rst=0.
//     Then iaddr=0 gives idin=1234 and iaddr=3 gives idin=5678.
//  2. RUN: dwe at daddr=0200 with ddout=ABCD -> led=00ABCD. dwe at 0202 with ddout=FF5A -> led=5AABCD, mem[0202..0203] unchanged.
//     doe at 0200 gives ddin=ABCD; doe at 0202 gives ddin=005A.
//  3. RUN: dwe at 0011 with ddout=BEEF -> mem[10]=BE, mem[11]=EF.
//     doe at 0010 same cycle gives old data; next cycle gives BEEF.
//  4. ld_start with ld_len=0 in HOLD -> DONE, then RUN two cycles later; ld_ready never asserted.
//  5. Reset mid-load after 2 of 8 bytes -> cpu_rst=1 and ld_ready=0 immediately.
//     Reload of 8 bytes starts at address 0; the first 2 old bytes are overwritten.
//  6. Loader stalls (ld_valid=0) for 5 cycles and dwe is pulsed during LOAD -> no extra writes, cnt held, RAM unchanged by dwe.

Source files
------------

// File: rtl/risc16_pkg.sv
// Shared types and default MMIO addresses for the risc16 memory responder.
package risc16_pkg;

    typedef enum logic [1:0] {
        HOLD,
        LOAD,
        DONE,
        RUN
    } resp_state_t;

    localparam logic [15:0] LED0_ADDR_DEFAULT = 16'h0200;
    localparam logic [15:0] LED2_ADDR_DEFAULT = 16'h0202;

endpackage

// File: rtl/risc16_byte_ram.sv
// Byte-organised RAM with two combinational big-endian word read ports and one
// write port that stores either a single byte or an aligned 16-bit word.
module risc16_byte_ram #(
    parameter int MEM_BYTES = 4096,
    parameter int AW        = $clog2(MEM_BYTES)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          we_word,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] a_addr,
    output logic [15:0]   a_word,
    input  logic [AW-1:0] b_addr,
    output logic [15:0]   b_word
);

    logic [7:0] mem [MEM_BYTES];

    // Word reads ignore the address LSB; the lower address holds the high byte.
    logic [AW-1:0] a_hi_idx, a_lo_idx, b_hi_idx, b_lo_idx;
    logic [AW-1:0] w_hi_idx, w_lo_idx;
    logic          unused_lsb;

    assign a_hi_idx = {a_addr[AW-1:1], 1'b0};
    assign a_lo_idx = {a_addr[AW-1:1], 1'b1};
    assign b_hi_idx = {b_addr[AW-1:1], 1'b0};
    assign b_lo_idx = {b_addr[AW-1:1], 1'b1};
    assign w_hi_idx = {waddr[AW-1:1], 1'b0};
    assign w_lo_idx = {waddr[AW-1:1], 1'b1};

    assign a_word = {mem[a_hi_idx], mem[a_lo_idx]};
    assign b_word = {mem[b_hi_idx], mem[b_lo_idx]};

    assign unused_lsb = a_addr[0] ^ b_addr[0];

    // Store one loader byte, or both halves of an aligned CPU word; contents are never cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            if (we_word) begin
                mem[w_hi_idx] <= wdata[15:8];
                mem[w_lo_idx] <= wdata[7:0];
            end else begin
                mem[waddr] <= wdata[7:0];
            end
        end
    end

endmodule

// File: rtl/risc16_mem_responder.sv
// Memory/MMIO responder for risc16f: keeps the CPU in reset while a byte-stream
// loader fills program memory, then serves instruction/data reads, RAM writes
// and the LED registers.
module risc16_mem_responder
    import risc16_pkg::*;
#(
    parameter int          MEM_BYTES = 4096,
    parameter logic [15:0] LED0_ADDR = LED0_ADDR_DEFAULT,
    parameter logic [15:0] LED2_ADDR = LED2_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] iaddr,
    input  logic        ioe,
    output logic [15:0] idin,
    input  logic [15:0] daddr,
    input  logic        doe,
    input  logic        dwe,
    input  logic [15:0] ddout,
    output logic [15:0] ddin,
    input  logic        ld_start,
    input  logic [15:0] ld_len,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    output logic        cpu_rst,
    output logic        ld_done,
    output logic [23:0] led
);

    localparam int AW = $clog2(MEM_BYTES);

    resp_state_t state_q, state_d;
    logic [15:0] cnt_q;
    logic [15:0] len_q;

    logic        load_xfer;
    logic        last_xfer;
    logic        cpu_wr;
    logic        led0_hit;
    logic        led2_hit;

    logic          ram_we;
    logic          ram_we_word;
    logic [AW-1:0] ram_waddr;
    logic [15:0]   ram_wdata;
    logic [15:0]   iword;
    logic [15:0]   dword;
    logic          unused_addr_bits;

    // The full 16-bit transfer count decides completion; only its low bits address
    // RAM, so loads longer than the memory wrap around and overwrite from 0.
    assign load_xfer = (state_q == LOAD) && ld_valid;
    assign last_xfer = load_xfer && (cnt_q == (len_q - 16'd1));
    assign cpu_wr    = (state_q == RUN) && dwe;
    assign led0_hit  = (daddr == LED0_ADDR);
    assign led2_hit  = (daddr == LED2_ADDR);

    assign unused_addr_bits = ^{iaddr, daddr};

    // State register; reset always parks the responder in HOLD with the CPU held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and loader handshake outputs; ld_start only matters in HOLD.
    always_comb begin
        state_d  = state_q;
        ld_ready = 1'b0;
        ld_done  = 1'b0;
        cpu_rst  = 1'b1;
        case (state_q)
            HOLD: begin
                if (ld_start) begin
                    state_d = (ld_len != 16'd0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                ld_ready = 1'b1;
                if (last_xfer) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ld_done = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                cpu_rst = 1'b0;
            end
            default: begin
                state_d = HOLD;
            end
        endcase
    end

    // Latch the requested length and restart the byte counter when a load begins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 16'd0;
            len_q <= 16'd0;
        end else if ((state_q == HOLD) && ld_start) begin
            cnt_q <= 16'd0;
            len_q <= ld_len;
        end else if (load_xfer) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    // LED registers accept CPU writes only once the CPU is running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led <= 24'h000000;
        end else if (cpu_wr) begin
            if (led0_hit) begin
                led[15:0] <= ddout;
            end else if (led2_hit) begin
                led[23:16] <= ddout[7:0];
            end
        end
    end

    // RAM write port mux: loader bytes during LOAD, CPU words in RUN except to LED addresses.
    always_comb begin
        ram_we      = 1'b0;
        ram_we_word = 1'b0;
        ram_waddr   = cnt_q[AW-1:0];
        ram_wdata   = {8'h00, ld_data};
        if (load_xfer) begin
            ram_we = 1'b1;
        end else if (cpu_wr && !led0_hit && !led2_hit) begin
            ram_we      = 1'b1;
            ram_we_word = 1'b1;
            ram_waddr   = daddr[AW-1:0];
            ram_wdata   = ddout;
        end
    end

    risc16_byte_ram #(
        .MEM_BYTES (MEM_BYTES),
        .AW        (AW)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .we_word (ram_we_word),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .a_addr  (iaddr[AW-1:0]),
        .a_word  (iword),
        .b_addr  (daddr[AW-1:0]),
        .b_word  (dword)
    );

    // Zero-latency read muxes; the data port sees the LED registers at their MMIO addresses.
    always_comb begin
        idin = 16'h0000;
        ddin = 16'h0000;
        if (ioe) begin
            idin = iword;
        end
        if (doe) begin
            if (led0_hit) begin
                ddin = led[15:0];
            end else if (led2_hit) begin
                ddin = {8'h00, led[23:16]};
            end else begin
                ddin = dword;
            end
        end
    end

endmodule

// File: tb/tb_risc16_mem_responder.sv
// Self-checking bench for risc16_mem_responder: load sequencing, reset behaviour,
// MMIO decode and combinational read/write timing.
module tb_risc16_mem_responder;

    logic        clk;
    logic        rst;
    logic [15:0] iaddr;
    logic        ioe;
    logic [15:0] idin;
    logic [15:0] daddr;
    logic        doe;
    logic        dwe;
    logic [15:0] ddout;
    logic [15:0] ddin;
    logic        ld_start;
    logic [15:0] ld_len;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        cpu_rst;
    logic        ld_done;
    logic [23:0] led;

    int total_count = 0;
    int pass_count  = 0;

    typedef struct {
        logic        ioe;
        logic [15:0] iaddr;
        logic        doe;
        logic [15:0] daddr;
        logic        dwe;
        logic [15:0] ddout;
        logic [15:0] exp_idin;
        logic [15:0] exp_ddin;
        logic [23:0] exp_led;
    } vec_t;

    vec_t vecs [9];

    risc16_mem_responder #(
        .MEM_BYTES (4096),
        .LED0_ADDR (16'h0200),
        .LED2_ADDR (16'h0202)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .iaddr    (iaddr),
        .ioe      (ioe),
        .idin     (idin),
        .daddr    (daddr),
        .doe      (doe),
        .dwe      (dwe),
        .ddout    (ddout),
        .ddin     (ddin),
        .ld_start (ld_start),
        .ld_len   (ld_len),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .cpu_rst  (cpu_rst),
        .ld_done  (ld_done),
        .led      (led)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [23:0] act, input logic [23:0] exp);
        total_count++;
        if (act === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        ld_valid = 1'b1;
        ld_data  = d;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic do_reset(input string name);
        rst = 1'b0;
        #1;
        check_output({name, "_cpu_rst"}, {23'd0, cpu_rst}, 24'd1);
        check_output({name, "_ld_ready"}, {23'd0, ld_ready}, 24'd0);
        tick();
        rst = 1'b1;
    endtask

    task automatic apply_stimulus(input vec_t v);
        ioe   = v.ioe;
        iaddr = v.iaddr;
        doe   = v.doe;
        daddr = v.daddr;
        dwe   = v.dwe;
        ddout = v.ddout;
    endtask

    function automatic logic [7:0] big_pattern(input logic [15:0] i);
        return i[7:0] ^ {4'h0, i[15:12]};
    endfunction

    initial begin
        // RUN-phase vectors applied after the wrapping 4100-byte load:
        // bytes 0..3 = 01 00 03 02, every other byte n = n[7:0].
        vecs[0] = '{1'b1, 16'h0000, 1'b1, 16'h0002, 1'b0, 16'h0000, 16'h0100, 16'h0302, 24'h000000};
        vecs[1] = '{1'b1, 16'h0202, 1'b1, 16'h0200, 1'b1, 16'hABCD, 16'h0203, 16'h0000, 24'h000000};
        vecs[2] = '{1'b1, 16'h0203, 1'b1, 16'h0200, 1'b0, 16'h0000, 16'h0203, 16'hABCD, 24'h00ABCD};
        vecs[3] = '{1'b1, 16'h0202, 1'b1, 16'h0202, 1'b1, 16'hFF5A, 16'h0203, 16'h0000, 24'h00ABCD};
        vecs[4] = '{1'b1, 16'h0202, 1'b1, 16'h0202, 1'b0, 16'h0000, 16'h0203, 16'h005A, 24'h5AABCD};
        vecs[5] = '{1'b1, 16'h0010, 1'b1, 16'h0011, 1'b1, 16'hBEEF, 16'h1011, 16'h1011, 24'h5AABCD};
        vecs[6] = '{1'b1, 16'h0011, 1'b1, 16'h0010, 1'b0, 16'h0000, 16'hBEEF, 16'hBEEF, 24'h5AABCD};
        vecs[7] = '{1'b0, 16'h0010, 1'b0, 16'h0010, 1'b0, 16'h0000, 16'h0000, 16'h0000, 24'h5AABCD};
        vecs[8] = '{1'b1, 16'h1002, 1'b1, 16'h0201, 1'b0, 16'h0000, 16'h0302, 16'h0001, 24'h5AABCD};

        rst      = 1'b0;
        iaddr    = 16'h0000;
        ioe      = 1'b0;
        daddr    = 16'h0000;
        doe      = 1'b0;
        dwe      = 1'b0;
        ddout    = 16'h0000;
        ld_start = 1'b0;
        ld_len   = 16'h0000;
        ld_valid = 1'b0;
        ld_data  = 8'h00;

        #2;
        check_output("rst_cpu_rst", {23'd0, cpu_rst}, 24'd1);
        check_output("rst_ld_ready", {23'd0, ld_ready}, 24'd0);
        check_output("rst_ld_done", {23'd0, ld_done}, 24'd0);
        check_output("rst_led", led, 24'h000000);
        tick();
        tick();
        rst = 1'b1;

        // Four-byte load, then instruction fetches.
        ld_start = 1'b1;
        ld_len   = 16'd4;
        tick();
        ld_start = 1'b0;
        check_output("l4_ready", {23'd0, ld_ready}, 24'd1);
        check_output("l4_cpu_rst_load", {23'd0, cpu_rst}, 24'd1);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        check_output("l4_no_early_done", {23'd0, ld_done}, 24'd0);
        send_byte(8'h78);
        check_output("l4_done", {23'd0, ld_done}, 24'd1);
        check_output("l4_cpu_rst_done", {23'd0, cpu_rst}, 24'd1);
        check_output("l4_ready_done", {23'd0, ld_ready}, 24'd0);
        tick();
        check_output("l4_done_pulse_end", {23'd0, ld_done}, 24'd0);
        check_output("l4_cpu_run", {23'd0, cpu_rst}, 24'd0);
        ioe   = 1'b1;
        iaddr = 16'h0000;
        #1;
        check_output("l4_idin0", {8'd0, idin}, 24'h001234);
        iaddr = 16'h0003;
        #1;
        check_output("l4_idin3", {8'd0, idin}, 24'h005678);
        ioe = 1'b0;
        #1;
        check_output("l4_idin_off", {8'd0, idin}, 24'h000000);
        tick();

        // Zero-length load goes straight through DONE into RUN.
        do_reset("z");
        ld_start = 1'b1;
        ld_len   = 16'd0;
        tick();
        ld_start = 1'b0;
        check_output("z_done", {23'd0, ld_done}, 24'd1);
        check_output("z_ready", {23'd0, ld_ready}, 24'd0);
        check_output("z_cpu_rst", {23'd0, cpu_rst}, 24'd1);
        tick();
        check_output("z_run_cpu_rst", {23'd0, cpu_rst}, 24'd0);
        check_output("z_run_done", {23'd0, ld_done}, 24'd0);
        ld_start = 1'b1;
        ld_len   = 16'd5;
        tick();
        ld_start = 1'b0;
        check_output("z_start_ignored_ready", {23'd0, ld_ready}, 24'd0);
        check_output("z_start_ignored_cpu", {23'd0, cpu_rst}, 24'd0);

        // Reset in the middle of a load, then a full reload with stalls and stray CPU writes.
        do_reset("m");
        ld_start = 1'b1;
        ld_len   = 16'd8;
        tick();
        ld_start = 1'b0;
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst = 1'b0;
        #1;
        check_output("m_mid_cpu_rst", {23'd0, cpu_rst}, 24'd1);
        check_output("m_mid_ready", {23'd0, ld_ready}, 24'd0);
        tick();
        rst = 1'b1;
        ld_start = 1'b1;
        ld_len   = 16'd8;
        tick();
        ld_start = 1'b0;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        for (int k = 0; k < 5; k++) begin
            ld_valid = 1'b0;
            dwe      = 1'b1;
            daddr    = (k == 2) ? 16'h0200 : 16'h0004;
            ddout    = 16'hDEAD;
            ld_start = (k == 1);
            ld_len   = 16'd2;
            tick();
        end
        dwe      = 1'b0;
        ld_start = 1'b0;
        daddr    = 16'h0000;
        #1;
        check_output("m_stall_ready", {23'd0, ld_ready}, 24'd1);
        check_output("m_stall_done", {23'd0, ld_done}, 24'd0);
        check_output("m_stall_led", led, 24'h000000);
        send_byte(8'h05);
        send_byte(8'h06);
        send_byte(8'h07);
        check_output("m_no_early_done", {23'd0, ld_done}, 24'd0);
        send_byte(8'h08);
        check_output("m_done", {23'd0, ld_done}, 24'd1);
        tick();
        check_output("m_run", {23'd0, cpu_rst}, 24'd0);
        ioe   = 1'b1;
        doe   = 1'b1;
        iaddr = 16'h0000;
        daddr = 16'h0004;
        #1;
        check_output("m_word0", {8'd0, idin}, 24'h000102);
        check_output("m_word4", {8'd0, ddin}, 24'h000506);
        iaddr = 16'h0006;
        daddr = 16'h0002;
        #1;
        check_output("m_word6", {8'd0, idin}, 24'h000708);
        check_output("m_word2", {8'd0, ddin}, 24'h000304);
        ioe = 1'b0;
        doe = 1'b0;
        tick();

        // Load longer than memory: wraps and overwrites bytes 0..3.
        do_reset("w");
        ld_start = 1'b1;
        ld_len   = 16'd4100;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1;
        for (int i = 0; i < 4100; i++) begin
            ld_data = big_pattern(16'(i));
            tick();
        end
        ld_valid = 1'b0;
        check_output("w_done", {23'd0, ld_done}, 24'd1);
        tick();
        check_output("w_run", {23'd0, cpu_rst}, 24'd0);

        for (int v = 0; v < 9; v++) begin
            apply_stimulus(vecs[v]);
            #1;
            check_output($sformatf("vec%0d_idin", v), {8'd0, idin}, {8'd0, vecs[v].exp_idin});
            check_output($sformatf("vec%0d_ddin", v), {8'd0, ddin}, {8'd0, vecs[v].exp_ddin});
            check_output($sformatf("vec%0d_led", v), led, vecs[v].exp_led);
            tick();
        end
        dwe = 1'b0;

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
